// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and also executes MTHI/MTLO.
// Multiply retires MUL_STEP bits per enabled edge; divide does one restoring step per edge.
module mips_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clock_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MUL_N = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic                      signed_op, rs_neg, rt_neg;
    logic [WIDTH-1:0]          rs_mag, rt_mag;
    logic [MUL_STEP-1:0]       digit;
    logic [WIDTH+MUL_STEP-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_next, div_next, prod_fix;
    logic [WIDTH:0]            rem_shift, rem_diff;
    logic [WIDTH-1:0]          quot_fix, rem_fix;

    // Datapath: operand magnitudes, one iteration step of each algorithm, and sign fix-up.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        rs_neg    = signed_op & rs[WIDTH-1];
        rt_neg    = signed_op & rt[WIDTH-1];
        rs_mag    = rs_neg ? (~rs + 1'b1) : rs;
        rt_mag    = rt_neg ? (~rt + 1'b1) : rt;

        // acc = {partial product, unretired multiplier bits}
        digit    = acc_q[MUL_STEP-1:0];
        mul_sum  = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}
                 + ({{MUL_STEP{1'b0}}, b_q} * {{WIDTH{1'b0}}, digit});
        mul_next = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};

        // acc = {partial remainder, dividend bits shifting into quotient}
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        div_next  = rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix = div_zero_q ? '1
                 : (neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
        rem_fix  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = done_q;
        if (clock_enable) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MTHI: begin
                                hi_d   = rs;
                                done_d = 1'b1;
                            end
                            OP_MTLO: begin
                                lo_d   = rs;
                                done_d = 1'b1;
                            end
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_d    = ST_RUN;
                                is_div_d   = (op == OP_DIV) || (op == OP_DIVU);
                                cnt_d      = is_div_d ? CW'(WIDTH) : CW'(MUL_N);
                                acc_d      = {{WIDTH{1'b0}}, rs_mag};
                                b_d        = rt_mag;
                                neg_lo_d   = rs_neg ^ rt_neg;
                                // Remainder follows the dividend; for multiply both halves share the product sign.
                                neg_hi_d   = is_div_d ? rs_neg : (rs_neg ^ rt_neg);
                                div_zero_d = is_div_d && (rt == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        acc_d = is_div_q ? div_next : mul_next;
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quot_fix;
                        end else begin
                            {hi_d, lo_d} = prod_fix;
                        end
                        done_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: default 32-bit instance plus a WIDTH=16, MUL_STEP=4 instance.
module tb_mips_muldiv_unit;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    logic        ce = 1'b1, flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = '0, rt = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start16 = 1'b0;
    logic [2:0]  op16 = 3'd0;
    logic [15:0] rs16 = '0, rt16 = '0;
    logic        busy16, done16;
    logic [15:0] hi16, lo16;

    mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk(clk), .reset(reset), .clock_enable(ce), .start(start), .op(op),
        .rs(rs), .rt(rt), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.WIDTH(16), .MUL_STEP(4)) dut16 (
        .clk(clk), .reset(reset), .clock_enable(ce), .start(start16), .op(op16),
        .rs(rs16), .rt(rt16), .flush(flush), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    // scoreboard
    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0, model_lo = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; rs = '0; rt = '0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int          edges, bc;
        logic [63:0] exp;
        bit          is_mt;
        is_mt = (o == OP_MTHI) || (o == OP_MTLO);
        exp_q.push_back({eh, el});
        issue(o, a, b);
        if (!is_mt) check_eq({tag, "_stale"}, {hi, lo}, {model_hi, model_lo});
        wait_done(edges, bc);
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_lat"}, 64'(edges), is_mt ? 64'd0 : 64'd33);
        check_eq({tag, "_busy"}, 64'(bc), is_mt ? 64'd0 : 64'd33);
        exp = exp_q.pop_front();
        check_eq({tag, "_hilo"}, {hi, lo}, exp);
        {model_hi, model_lo} = exp;
        @(negedge clk);
        check_eq({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run16(input string tag, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp);
        int e16;
        @(negedge clk);
        start16 = 1'b1; op16 = o; rs16 = a; rt16 = b;
        @(negedge clk);
        start16 = 1'b0;
        e16 = 0;
        while (!done16 && e16 < 50) begin
            @(negedge clk);
            e16++;
        end
        check_eq({tag, "_done"}, 64'(done16), 64'd1);
        check_eq({tag, "_lat"}, 64'(e16), 64'd5);
        check_eq({tag, "_hilo"}, 64'({hi16, lo16}), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int edges, bc, n_done;

        repeat (2) @(negedge clk);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        reset = 1'b1;

        run_op("mult",    OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu",   OP_MULTU, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1);
        run_op("multmin", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("divu",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div_neg", OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_nd",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op("divu_z",  OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_z",   OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_op("mthi",    OP_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, model_lo);
        run_op("mtlo",    OP_MTLO,  32'h0BAD_F00D, 32'd0,         32'h1234_5678, 32'h0BAD_F00D);

        // start while busy is dropped
        exp_q.push_back({32'd0, 32'd42});
        issue(OP_MULT, 32'd7, 32'd6);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MTLO; rs = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; rs = '0;
        check_eq("ign_busy", 64'(busy), 64'd1);
        wait_done(edges, bc);
        check_eq("ign_lat", 64'(edges + 5), 64'd33);
        check_eq("ign_hilo", {hi, lo}, exp_q.pop_front());
        {model_hi, model_lo} = {32'd0, 32'd42};
        @(negedge clk);
        check_eq("ign_after", {hi, lo}, {model_hi, model_lo});

        // clock_enable low for 5 cycles mid-run
        exp_q.push_back({32'd1, 32'd0});
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        repeat (10) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("stall_busy", 64'(busy), 64'd1);
        check_eq("stall_stale", {hi, lo}, {model_hi, model_lo});
        ce = 1'b1;
        wait_done(edges, bc);
        check_eq("stall_lat", 64'(edges + 15), 64'd38);
        check_eq("stall_hilo", {hi, lo}, exp_q.pop_front());
        {model_hi, model_lo} = {32'd1, 32'd0};

        // flush at cycle 10 of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_hilo", {hi, lo}, {model_hi, model_lo});
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("flush_nodone", 64'(n_done), 64'd0);
        check_eq("flush_hilo2", {hi, lo}, {model_hi, model_lo});

        // asynchronous reset mid-MULT
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        repeat (10) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("arst_hilo", {hi, lo}, 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        {model_hi, model_lo} = 64'd0;
        run_op("post_rst", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // WIDTH=16, MUL_STEP=4 instance
        run16("w16_mult",  OP_MULT,  16'h8000, 16'h8000, 32'h4000_0000);
        run16("w16_multu", OP_MULTU, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run16("w16_mneg",  OP_MULT,  16'hFFFD, 16'd5,    32'hFFFF_FFF1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
